chunked_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's 32-bit combinational ripple adder. It adds two WIDTH-bit operands CHUNK bits per clock, least-significant slice first, and carries the partial carry between cycles in a register. A start/busy/done handshake lets a controller trade latency for adder area. Results and flags hold stable until the next accepted operation.

---
 rtl/chunked_adder.sv | 99 +++++++++
 tb/tb_chunked_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB slice first,
// carrying the partial carry between cycles; start/busy/done handshake.
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IW-1:0]    idx;

    int               base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic             last_slice;

    // Handshake: start is accepted on any edge where busy = 0 (IDLE or DONE);
    // operands are sampled on that edge only, and done pulses for one cycle
    // when z/cout/ovf are valid. They then hold until the next accept.
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        base       = int'(idx) * CHUNK;
        a_slice    = a_reg[base +: CHUNK];
        b_slice    = b_reg[base +: CHUNK];
        slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        last_slice = (idx == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            z     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1, so cout = 1 means no borrow.
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        z     <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    z[base +: CHUNK] <= slice_sum[CHUNK-1:0];
                    carry            <= slice_sum[CHUNK];
                    if (last_slice) begin
                        idx   <= '0;
                        cout  <= slice_sum[CHUNK];
                        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: five instances (CHUNK = 8,1,4,16,32)
// share stimulus; results are compared with an arithmetic reference model.
module tb_chunked_adder;

    localparam int W  = 32;
    localparam int NI = 5;
    localparam int CH [NI] = '{8, 1, 4, 16, 32};

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sub;
    logic          cin;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [NI-1:0] cout_v;
    logic [NI-1:0] ovf_v;
    logic [W-1:0]  z_v   [NI];
    logic [1:0]    st_v  [NI];

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [33:0]   exp_q[$];   // {cout, ovf, z}

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            chunked_adder #(.WIDTH(W), .CHUNK(CH[g])) dut (
                .clk      (clk),
                .reset    (reset),
                .start    (start),
                .sub      (sub),
                .a        (a),
                .b        (b),
                .cin      (cin),
                .busy     (busy_v[g]),
                .done     (done_v[g]),
                .z        (z_v[g]),
                .cout     (cout_v[g]),
                .ovf      (ovf_v[g]),
                .dbg_state(st_v[g])
            );
        end
    endgenerate

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] ez;
        logic         ec;
        logic         eo;
    } vec_t;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical operands.
    function automatic logic [33:0] model(input logic s, input logic [W-1:0] aa,
                                          input logic [W-1:0] bb, input logic ci);
        longint       r;
        longint       sr;
        logic [W-1:0] zz;
        logic         c;
        logic         o;
        if (s) begin
            zz = aa - bb;
            c  = (aa >= bb);
            sr = longint'($signed(aa)) - longint'($signed(bb));
        end else begin
            r  = longint'(aa) + longint'(bb) + (ci ? 64'sd1 : 64'sd0);
            zz = r[31:0];
            c  = r[32];
            sr = longint'($signed(aa)) + longint'($signed(bb)) + (ci ? 64'sd1 : 64'sd0);
        end
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {c, o, zz};
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // One operation on all instances; checks results and busy length at each done.
    task automatic do_op(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input logic [33:0] exp, input string tag);
        bit [NI-1:0] seen;
        int          bc [NI];
        int          cyc;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b1; sub = s; a = aa; b = bb; cin = ci;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        seen = '0;
        for (int k = 0; k < NI; k++) bc[k] = 0;
        cyc = 0;
        while (seen != '1 && cyc < 40) begin
            for (int k = 0; k < NI; k++) begin
                if (!seen[k]) begin
                    if (done_v[k]) begin
                        check($sformatf("%s inst%0d z", tag, k), {2'b0, z_v[k]}, {2'b0, exp_q[0][31:0]});
                        check($sformatf("%s inst%0d cout", tag, k), {33'b0, cout_v[k]}, {33'b0, exp_q[0][33]});
                        check($sformatf("%s inst%0d ovf", tag, k), {33'b0, ovf_v[k]}, {33'b0, exp_q[0][32]});
                        check($sformatf("%s inst%0d busy_cycles", tag, k), 34'(bc[k]), 34'(W / CH[k]));
                        seen[k] = 1'b1;
                    end else if (busy_v[k]) begin
                        bc[k]++;
                    end
                end
            end
            if (seen != '1) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (seen != '1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: done seen %b required %b", tag, seen, {NI{1'b1}});
        end
        void'(exp_q.pop_front());
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done_v[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        vec_t         vecs [8];
        int           cyc;
        logic         s;
        logic         ci;
        logic [W-1:0] aa;
        logic [W-1:0] bb;

        vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

        // Reset, then idle with start low.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check($sformatf("idle c%0d inst%0d busy", c, k), {33'b0, busy_v[k]}, 34'd0);
                check($sformatf("idle c%0d inst%0d done", c, k), {33'b0, done_v[k]}, 34'd0);
                check($sformatf("idle c%0d inst%0d outs", c, k), {cout_v[k], ovf_v[k], z_v[k]}, 34'd0);
            end
        end

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ci,
                  {vecs[i].ec, vecs[i].eo, vecs[i].ez}, $sformatf("vec%0d", i));

        // start pulsed mid-RUN must be ignored (instance 0, CHUNK = 8).
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'd10; b = 32'd20; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 32'd1000; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done0(cyc);
        check("midrun latency", 34'(cyc), 34'd2);
        check("midrun z", {2'b0, z_v[0]}, 34'd30);
        @(negedge clk);
        check("midrun no restart busy", {33'b0, busy_v[0]}, 34'd0);
        check("midrun done one cycle", {33'b0, done_v[0]}, 34'd0);
        do_reset(1);

        // start held through DONE: second op accepted at edge N+1.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'd1; b = 32'd2; cin = 1'b0;
        @(negedge clk);
        wait_done0(cyc);
        check("held first latency", 34'(cyc), 34'd4);
        check("held first z", {2'b0, z_v[0]}, 34'd3);
        a = 32'd100; b = 32'd200;
        @(negedge clk);
        check("held restart busy", {33'b0, busy_v[0]}, 34'd1);
        check("held restart done", {33'b0, done_v[0]}, 34'd0);
        start = 1'b0;
        wait_done0(cyc);
        check("held second latency", 34'(cyc), 34'd4);
        check("held second z", {2'b0, z_v[0]}, 34'd300);
        do_reset(1);

        // Reset at slice 2 clears everything, including held ovf.
        do_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, model(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0), "pre_reset");
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("partial z slice0", {2'b0, z_v[0]}, 34'h33);
        check("ovf holds during run", {33'b0, ovf_v[0]}, 34'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("midreset inst%0d busy", k), {33'b0, busy_v[k]}, 34'd0);
            check($sformatf("midreset inst%0d done", k), {33'b0, done_v[k]}, 34'd0);
            check($sformatf("midreset inst%0d outs", k), {cout_v[k], ovf_v[k], z_v[k]}, 34'd0);
        end
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check($sformatf("reset beats start inst%0d", k), {33'b0, busy_v[k]}, 34'd0);
        reset = 1'b0;
        start = 1'b0;

        // Randomised sweep against the reference model.
        for (int i = 0; i < 200; i++) begin
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            aa = $urandom;
            bb = $urandom;
            if ($urandom_range(0, 7) == 0) aa = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) bb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0000_0000;
            do_op(s, aa, bb, ci, model(s, aa, bb, ci), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
